dma_frame_buffer_ctrl: RTL and testbench
========================================

Name: dma_frame_buffer_ctrl

Overview:
- Frame-buffer manager for the video write DMA; sits directly upstream of the DMA debug counters.
- Rotates the write DMA through a ring of frame buffers in DDR.
- On each completed frame it pushes the finished buffer address into the buffer-address FIFO (buff_addr_fifo_wen_o) and raises a level interrupt to the processor (interrupt_o).
- Counts frames dropped on FIFO back-pressure and frames aborted by protocol errors.

Parameters:
- ADDR_WIDTH, 32, width of DDR byte addresses, base and stride.
- BUF_IDX_WIDTH, 3, width of num_buffers_i and the buffer index (max 7 buffers).
- CNT_WIDTH, 16, width of the drop and error counters.

Ports:
- sys_clk_i  in  1  system clock
- rstn_i  in  1  asynchronous active-low reset
- enable_i  in  1  controller enable (register bit)
- base_addr_i  in  ADDR_WIDTH  address of buffer 0
- stride_i  in  ADDR_WIDTH  byte distance between consecutive buffers
- num_buffers_i  in  BUF_IDX_WIDTH  ring size; 0 treated as 1
- frame_start_i  in  1  one-cycle SOF pulse from the video write path
- frame_end_i  in  1  one-cycle EOF pulse (last beat written)
- int_clear_i  in  1  one-cycle interrupt clear from the processor
- buff_addr_fifo_full_i  in  1  buffer-address FIFO full
- wr_addr_o  out  ADDR_WIDTH  base address the write DMA uses for the current frame
- buf_idx_o  out  BUF_IDX_WIDTH  current buffer index
- buff_addr_fifo_wen_o  out  1  FIFO write strobe, one cycle
- buff_addr_fifo_data_o  out  ADDR_WIDTH  completed buffer address
- interrupt_o  out  1  level interrupt, frame available
- drop_count_o  out  CNT_WIDTH  frames dropped because the FIFO was full
- frame_error_count_o  out  CNT_WIDTH  frames aborted (SOF while ACTIVE)

Behaviour:
- Reset: rstn_i asynchronous, active-low; clock sys_clk_i. All outputs and counters reset to 0; state IDLE.
- FSM states: IDLE, WAIT_SOF, ACTIVE.
- IDLE -> WAIT_SOF when enable_i=1. At that edge:
  - latch base_addr_i, stride_i and num_buffers_i (0 maps to 1);
  - buf_idx_o <= 0; wr_addr_o <= base_addr_i.
- Configuration changes while not in IDLE are ignored until the next IDLE exit.
- WAIT_SOF:
  - frame_start_i -> ACTIVE.
  - enable_i=0 -> IDLE.
  - frame_end_i is ignored.
- ACTIVE, frame_end_i high in cycle N, registered at the end of cycle N:
  - FIFO not full (full_i sampled in cycle N):
    - buff_addr_fifo_wen_o=1 during cycle N+1 only; data_o = wr_addr_o of the completed frame.
    - interrupt_o set from N+1.
    - Advance the ring: if buf_idx_o = latched_num-1, then idx <= 0 and addr <= latched base; else idx <= idx+1 and addr <= addr + stride (modulo 2^ADDR_WIDTH). No multiplier.
  - FIFO full: no write, no interrupt, drop_count_o +1, buffer not advanced (the next frame overwrites it).
  - Next state: WAIT_SOF if enable_i=1, else IDLE.
- ACTIVE with frame_end_i and frame_start_i in the same cycle:
  - process EOF as above;
  - next state ACTIVE;
  - the new frame uses the post-advance wr_addr_o.
- ACTIVE with frame_start_i only (missing EOF):
  - frame_error_count_o +1;
  - stay ACTIVE on the same buffer; no FIFO write.
- enable_i=0 mid-frame: the current frame completes normally; return to IDLE after its EOF.
- interrupt_o: set by a successful commit, cleared by int_clear_i. Set wins on a simultaneous set and clear.
- Counters wrap modulo 2^CNT_WIDTH.
- Reset asserted mid-frame: immediate return to IDLE; no FIFO write is issued.

Decomposition:
- Shared include/package (alongside the DMA memory-map constants):
  - FSM state encodings;
  - default ADDR_WIDTH, BUF_IDX_WIDTH and CNT_WIDTH.
- One sub-module, dma_buf_ring_addr: holds the latched base, stride and num; provides load and advance inputs; outputs idx and addr.

Test Plan:
- Ring wrap: base=0x1000_0000, stride=0x0080_0000, num=3, 4 clean frames -> fifo data 0x1000_0000, 0x1080_0000, 0x1100_0000, 0x1000_0000; wen is exactly 1 cycle, one cycle after each EOF.
- Back-pressure: full_i=1 during the EOF of frame 2 -> no wen, drop_count_o=1, frame 3 reuses 0x1080_0000.
- Interrupt: commit then int_clear_i 5 cycles later -> interrupt_o high for 5 cycles. Clear on the same cycle as the next commit -> interrupt_o stays 1.
- Protocol errors:
  - SOF-SOF-EOF sequence -> frame_error_count_o=1, a single FIFO write of the original buffer.
  - EOF in WAIT_SOF -> nothing.
- Back-to-back: EOF and SOF in the same cycle -> wen once, new frame's wr_addr_o is already advanced.
- Enable and reset:
  - enable_i=0 mid-frame -> EOF still commits, FSM reaches IDLE.
  - num=0 -> single buffer, address stays at base.
  - rstn_i pulse mid-frame -> all outputs 0, no wen.

Source files
------------

// File: rtl/dma_frame_buffer_ctrl_pkg.sv
// Shared constants and FSM encoding for the video write DMA frame-buffer manager.
package dma_frame_buffer_ctrl_pkg;

    localparam int unsigned FBC_ADDR_WIDTH    = 32;
    localparam int unsigned FBC_BUF_IDX_WIDTH = 3;
    localparam int unsigned FBC_CNT_WIDTH     = 16;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WAIT_SOF = 2'd1,
        ST_ACTIVE   = 2'd2
    } fbc_state_e;

endpackage

// File: rtl/dma_frame_buffer_ctrl_if.sv
// Control, status and buffer-address FIFO signals of the frame-buffer manager.
interface dma_frame_buffer_ctrl_if
    import dma_frame_buffer_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH    = FBC_ADDR_WIDTH,
    parameter int unsigned BUF_IDX_WIDTH = FBC_BUF_IDX_WIDTH,
    parameter int unsigned CNT_WIDTH     = FBC_CNT_WIDTH
);
    logic                     enable_i;
    logic [ADDR_WIDTH-1:0]    base_addr_i;
    logic [ADDR_WIDTH-1:0]    stride_i;
    logic [BUF_IDX_WIDTH-1:0] num_buffers_i;
    logic                     frame_start_i;
    logic                     frame_end_i;
    logic                     int_clear_i;
    logic                     buff_addr_fifo_full_i;
    logic [ADDR_WIDTH-1:0]    wr_addr_o;
    logic [BUF_IDX_WIDTH-1:0] buf_idx_o;
    logic                     buff_addr_fifo_wen_o;
    logic [ADDR_WIDTH-1:0]    buff_addr_fifo_data_o;
    logic                     interrupt_o;
    logic [CNT_WIDTH-1:0]     drop_count_o;
    logic [CNT_WIDTH-1:0]     frame_error_count_o;

    // Processor / video path side
    modport master (
        output enable_i, base_addr_i, stride_i, num_buffers_i,
        output frame_start_i, frame_end_i, int_clear_i, buff_addr_fifo_full_i,
        input  wr_addr_o, buf_idx_o, buff_addr_fifo_wen_o, buff_addr_fifo_data_o,
        input  interrupt_o, drop_count_o, frame_error_count_o
    );

    // Controller side
    modport slave (
        input  enable_i, base_addr_i, stride_i, num_buffers_i,
        input  frame_start_i, frame_end_i, int_clear_i, buff_addr_fifo_full_i,
        output wr_addr_o, buf_idx_o, buff_addr_fifo_wen_o, buff_addr_fifo_data_o,
        output interrupt_o, drop_count_o, frame_error_count_o
    );

endinterface

// File: rtl/dma_buf_ring_addr.sv
// Buffer ring pointer: latches base/stride/size on load, steps index and address on advance.
module dma_buf_ring_addr
    import dma_frame_buffer_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH    = FBC_ADDR_WIDTH,
    parameter int unsigned BUF_IDX_WIDTH = FBC_BUF_IDX_WIDTH
) (
    input  logic                     sys_clk_i,
    input  logic                     rstn_i,
    input  logic                     load_i,
    input  logic                     advance_i,
    input  logic [ADDR_WIDTH-1:0]    base_i,
    input  logic [ADDR_WIDTH-1:0]    stride_i,
    input  logic [BUF_IDX_WIDTH-1:0] num_i,
    output logic [BUF_IDX_WIDTH-1:0] idx_o,
    output logic [ADDR_WIDTH-1:0]    addr_o
);

    logic [ADDR_WIDTH-1:0]    base_q;
    logic [ADDR_WIDTH-1:0]    stride_q;
    logic [BUF_IDX_WIDTH-1:0] last_idx_q;

    // Ring size 0 behaves as a single buffer, so the last index is 0 in both cases.
    logic [BUF_IDX_WIDTH-1:0] last_idx_c;
    assign last_idx_c = (num_i == '0) ? '0 : num_i - BUF_IDX_WIDTH'(1);

    // Configuration latch and ring stepping; the address is accumulated, not multiplied.
    always_ff @(posedge sys_clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            base_q     <= '0;
            stride_q   <= '0;
            last_idx_q <= '0;
            idx_o      <= '0;
            addr_o     <= '0;
        end else if (load_i) begin
            base_q     <= base_i;
            stride_q   <= stride_i;
            last_idx_q <= last_idx_c;
            idx_o      <= '0;
            addr_o     <= base_i;
        end else if (advance_i) begin
            if (idx_o == last_idx_q) begin
                idx_o  <= '0;
                addr_o <= base_q;
            end else begin
                idx_o  <= idx_o + BUF_IDX_WIDTH'(1);
                addr_o <= addr_o + stride_q;
            end
        end
    end

endmodule

// File: rtl/dma_frame_buffer_ctrl.sv
// Frame-buffer manager: rotates the write DMA through a DDR buffer ring and
// publishes each completed buffer to the address FIFO with an interrupt.
module dma_frame_buffer_ctrl
    import dma_frame_buffer_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH    = FBC_ADDR_WIDTH,
    parameter int unsigned BUF_IDX_WIDTH = FBC_BUF_IDX_WIDTH,
    parameter int unsigned CNT_WIDTH     = FBC_CNT_WIDTH
) (
    input  logic                     sys_clk_i,
    input  logic                     rstn_i,
    dma_frame_buffer_ctrl_if.slave   bus
);

    fbc_state_e state_q, state_d;

    logic load_c;
    logic commit_c;
    logic drop_c;
    logic error_c;

    logic [ADDR_WIDTH-1:0]    ring_addr;
    logic [BUF_IDX_WIDTH-1:0] ring_idx;

    logic                  wen_q;
    logic [ADDR_WIDTH-1:0] fifo_data_q;
    logic                  irq_q;
    logic [CNT_WIDTH-1:0]  drop_cnt_q;
    logic [CNT_WIDTH-1:0]  err_cnt_q;

    dma_buf_ring_addr #(
        .ADDR_WIDTH    (ADDR_WIDTH),
        .BUF_IDX_WIDTH (BUF_IDX_WIDTH)
    ) u_ring (
        .sys_clk_i (sys_clk_i),
        .rstn_i    (rstn_i),
        .load_i    (load_c),
        .advance_i (commit_c),
        .base_i    (bus.base_addr_i),
        .stride_i  (bus.stride_i),
        .num_i     (bus.num_buffers_i),
        .idx_o     (ring_idx),
        .addr_o    (ring_addr)
    );

    // FSM state register
    always_ff @(posedge sys_clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and per-cycle frame events
    always_comb begin
        state_d  = state_q;
        load_c   = 1'b0;
        commit_c = 1'b0;
        drop_c   = 1'b0;
        error_c  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (bus.enable_i) begin
                    load_c  = 1'b1;
                    state_d = ST_WAIT_SOF;
                end
            end
            ST_WAIT_SOF: begin
                if (bus.frame_start_i) begin
                    state_d = ST_ACTIVE;
                end else if (!bus.enable_i) begin
                    state_d = ST_IDLE;
                end
            end
            ST_ACTIVE: begin
                if (bus.frame_end_i) begin
                    // A full FIFO leaves the ring in place so the next frame overwrites it.
                    commit_c = !bus.buff_addr_fifo_full_i;
                    drop_c   = bus.buff_addr_fifo_full_i;
                    if (bus.frame_start_i) begin
                        state_d = ST_ACTIVE;
                    end else if (bus.enable_i) begin
                        state_d = ST_WAIT_SOF;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else if (bus.frame_start_i) begin
                    error_c = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FIFO strobe/data, interrupt level and event counters
    always_ff @(posedge sys_clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            wen_q       <= 1'b0;
            fifo_data_q <= '0;
            irq_q       <= 1'b0;
            drop_cnt_q  <= '0;
            err_cnt_q   <= '0;
        end else begin
            wen_q <= commit_c;
            if (commit_c) begin
                fifo_data_q <= ring_addr;
            end
            if (commit_c) begin
                irq_q <= 1'b1;
            end else if (bus.int_clear_i) begin
                irq_q <= 1'b0;
            end
            if (drop_c) begin
                drop_cnt_q <= drop_cnt_q + CNT_WIDTH'(1);
            end
            if (error_c) begin
                err_cnt_q <= err_cnt_q + CNT_WIDTH'(1);
            end
        end
    end

    assign bus.wr_addr_o             = ring_addr;
    assign bus.buf_idx_o             = ring_idx;
    assign bus.buff_addr_fifo_wen_o  = wen_q;
    assign bus.buff_addr_fifo_data_o = fifo_data_q;
    assign bus.interrupt_o           = irq_q;
    assign bus.drop_count_o          = drop_cnt_q;
    assign bus.frame_error_count_o   = err_cnt_q;

endmodule

// File: tb/tb_dma_frame_buffer_ctrl.sv
// Directed bench for dma_frame_buffer_ctrl with a FIFO-write scoreboard and a
// cycle-level reference model of ring position, interrupt and counters.
module tb_dma_frame_buffer_ctrl;
    import dma_frame_buffer_ctrl_pkg::*;

    localparam int unsigned AW = 32;
    localparam int unsigned IW = 3;
    localparam int unsigned CW = 16;

    logic sys_clk_i = 1'b0;
    logic rstn_i    = 1'b0;
    always #5 sys_clk_i = ~sys_clk_i;

    dma_frame_buffer_ctrl_if #(.ADDR_WIDTH(AW), .BUF_IDX_WIDTH(IW), .CNT_WIDTH(CW)) bus ();

    dma_frame_buffer_ctrl #(.ADDR_WIDTH(AW), .BUF_IDX_WIDTH(IW), .CNT_WIDTH(CW)) dut (
        .sys_clk_i (sys_clk_i),
        .rstn_i    (rstn_i),
        .bus       (bus.slave)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    string phase = "init";

    // Scoreboard: expected FIFO data and the negedge index at which wen must show it
    logic [31:0] exp_data_q[$];
    int          exp_cyc_q[$];

    // Reference model
    logic [31:0] m_base = '0, m_stride = '0;
    int          m_num = 0, m_idx = 0, m_state = 0, m_drop = 0, m_err = 0;
    logic        m_int = 1'b0;

    // Configuration applied on the next driven cycle
    logic        c_en = 1'b0;
    logic [31:0] c_base = '0, c_stride = '0;
    logic [2:0]  c_num = '0;

    always @(posedge sys_clk_i) cyc <= cyc + 1;

    function automatic logic [31:0] m_addr();
        return m_base + 32'(m_idx) * m_stride;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s [%s] observed=%0h expected=%0h", tag, phase, got, exp);
        end
    endtask

    task automatic check_state();
        chk("wr_addr", bus.wr_addr_o, m_addr());
        chk("buf_idx", 32'(bus.buf_idx_o), 32'(m_idx));
        chk("interrupt", 32'(bus.interrupt_o), 32'(m_int));
        chk("drop_count", 32'(bus.drop_count_o), 32'(m_drop));
        chk("error_count", 32'(bus.frame_error_count_o), 32'(m_err));
    endtask

    // One clock of stimulus: check previous-cycle outputs, apply inputs, step the model
    task automatic drive(input logic sof, input logic eof, input logic full, input logic clr);
        logic commit;
        @(negedge sys_clk_i);
        check_state();
        bus.enable_i              = c_en;
        bus.base_addr_i           = c_base;
        bus.stride_i              = c_stride;
        bus.num_buffers_i         = c_num;
        bus.frame_start_i         = sof;
        bus.frame_end_i           = eof;
        bus.buff_addr_fifo_full_i = full;
        bus.int_clear_i           = clr;
        commit = 1'b0;
        case (m_state)
            0: if (c_en) begin
                m_base = c_base; m_stride = c_stride;
                m_num = (c_num == 3'd0) ? 1 : int'(c_num);
                m_idx = 0; m_state = 1;
            end
            1: if (sof) m_state = 2; else if (!c_en) m_state = 0;
            2: if (eof) begin
                if (!full) begin
                    commit = 1'b1;
                    exp_data_q.push_back(m_addr());
                    exp_cyc_q.push_back(cyc + 1);
                    m_idx = (m_idx == m_num - 1) ? 0 : m_idx + 1;
                end else begin
                    m_drop++;
                end
                m_state = sof ? 2 : (c_en ? 1 : 0);
            end else if (sof) begin
                m_err++;
            end
            default: m_state = 0;
        endcase
        if (commit) m_int = 1'b1;
        else if (clr) m_int = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // SOF, two data cycles, EOF with the given FIFO-full level, one trailing idle
    task automatic frame(input logic full);
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        idle(2);
        drive(1'b0, 1'b1, full, 1'b0);
        idle(1);
    endtask

    task automatic do_reset();
        @(negedge sys_clk_i);
        rstn_i = 1'b0;
        bus.enable_i = 1'b0; bus.frame_start_i = 1'b0; bus.frame_end_i = 1'b0;
        bus.int_clear_i = 1'b0; bus.buff_addr_fifo_full_i = 1'b0;
        #1;
        chk("rst_wr_addr", bus.wr_addr_o, 32'h0);
        chk("rst_buf_idx", 32'(bus.buf_idx_o), 32'h0);
        chk("rst_wen", 32'(bus.buff_addr_fifo_wen_o), 32'h0);
        chk("rst_interrupt", 32'(bus.interrupt_o), 32'h0);
        chk("rst_drop", 32'(bus.drop_count_o), 32'h0);
        chk("rst_err", 32'(bus.frame_error_count_o), 32'h0);
        m_base = '0; m_stride = '0; m_num = 0; m_idx = 0; m_state = 0;
        m_drop = 0; m_err = 0; m_int = 1'b0;
        @(negedge sys_clk_i);
        rstn_i = 1'b1;
    endtask

    // FIFO write monitor: wen only on scheduled cycles, with the scheduled data
    always @(negedge sys_clk_i) begin
        if (exp_cyc_q.size() != 0 && exp_cyc_q[0] == cyc) begin
            chk("fifo_wen", 32'(bus.buff_addr_fifo_wen_o), 32'h1);
            chk("fifo_data", bus.buff_addr_fifo_data_o, exp_data_q[0]);
            void'(exp_cyc_q.pop_front());
            void'(exp_data_q.pop_front());
        end else begin
            chk("fifo_wen_idle", 32'(bus.buff_addr_fifo_wen_o), 32'h0);
        end
    end

    initial begin
        bus.enable_i = 1'b0; bus.base_addr_i = '0; bus.stride_i = '0; bus.num_buffers_i = '0;
        bus.frame_start_i = 1'b0; bus.frame_end_i = 1'b0; bus.int_clear_i = 1'b0;
        bus.buff_addr_fifo_full_i = 1'b0;

        phase = "reset";
        do_reset();
        idle(2);

        phase = "ring_wrap";
        c_base = 32'h1000_0000; c_stride = 32'h0080_0000; c_num = 3'd3; c_en = 1'b1;
        idle(1);
        frame(1'b0);
        phase = "int_clear";
        idle(3);
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        idle(1);
        chk("int_cleared", 32'(bus.interrupt_o), 32'h0);
        phase = "ring_wrap";
        frame(1'b0);
        frame(1'b0);
        frame(1'b0);
        chk("wrap_addr", bus.wr_addr_o, 32'h1080_0000);
        chk("wrap_idx", 32'(bus.buf_idx_o), 32'h1);

        phase = "backpressure";
        frame(1'b1);
        chk("drop_one", 32'(bus.drop_count_o), 32'h1);
        chk("reuse_addr", bus.wr_addr_o, 32'h1080_0000);

        phase = "clear_vs_set";
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        idle(1);
        drive(1'b0, 1'b1, 1'b0, 1'b1);
        idle(1);
        chk("set_wins", 32'(bus.interrupt_o), 32'h1);

        phase = "sof_sof_eof";
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        idle(1);
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        idle(1);
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        idle(1);
        chk("err_one", 32'(bus.frame_error_count_o), 32'h1);

        phase = "eof_in_wait";
        c_base = 32'h5000_0000;
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        idle(2);

        phase = "back_to_back";
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        idle(1);
        drive(1'b1, 1'b1, 1'b0, 1'b0);
        idle(1);
        chk("b2b_addr", bus.wr_addr_o, 32'h1080_0000);
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        idle(1);

        phase = "disable_mid_frame";
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        c_en = 1'b0;
        idle(1);
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        idle(2);
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        idle(2);

        phase = "num_zero";
        c_base = 32'h2000_0000; c_stride = 32'h0000_0100; c_num = 3'd0; c_en = 1'b1;
        idle(1);
        frame(1'b0);
        frame(1'b0);
        chk("single_buf_addr", bus.wr_addr_o, 32'h2000_0000);

        phase = "reset_mid_frame";
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        idle(1);
        do_reset();
        idle(2);
        frame(1'b0);
        idle(3);

        chk("sb_drained", 32'(exp_cyc_q.size()), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
